// File: rtl/aes_key_expand_pkg.sv
// Shared AES key-schedule definitions: FSM encoding, forward S-box, xtime and
// derivation of the round/word counts from the key length.
package aes_key_expand_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        FIN
    } state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int nw_of(input int nk);
        return 4 * (nr_of(nk) + 1);
    endfunction

endpackage

// File: rtl/aes_key_expand_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
module aes_key_expand_sub_word
    import aes_key_expand_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign sub[8*gi +: 8] = sbox(word[8*gi +: 8]);
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule for 128/192/256-bit keys, one 32-bit word per clock,
// presenting all round keys on a flat bus with w[0] at the low bit indices.
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter  int Nk = 4,
    localparam int Nr = nr_of(Nk),
    localparam int NW = nw_of(Nk)
) (
    input  logic                   clks,
    input  logic                   reset,
    input  logic                   start,
    input  logic [0:32*Nk-1]       key_in,
    output logic                   busy,
    output logic                   done,
    output logic                   keys_valid,
    output logic [0:128*(Nr+1)-1]  keys
);

    state_t      state_reg;
    logic [5:0]  i_reg;
    logic [2:0]  wrap_reg;
    logic [7:0]  rcon_reg;
    logic [31:0] w_reg [NW];

    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;

    for (genvar gi = 0; gi < NW; gi++) begin : g_keys
        assign keys[32*gi +: 32] = w_reg[gi];
    end

    assign prev_word = w_reg[i_reg - 6'd1];
    assign back_word = w_reg[i_reg - 6'(Nk)];

    // One S-box bank serves both the RotWord step and the Nk=8 mid-key step.
    assign sub_in = (wrap_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_key_expand_sub_word u_sub_word (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        temp = prev_word;
        if (wrap_reg == 3'd0) begin
            temp = sub_out ^ {rcon_reg, 24'h0};
        end else if (Nk == 8 && wrap_reg == 3'd4) begin
            temp = sub_out;
        end
    end

    always_ff @(posedge clks) begin
        if (reset) begin
            state_reg  <= IDLE;
            i_reg      <= '0;
            wrap_reg   <= '0;
            rcon_reg   <= RCON_INIT;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            for (int k = 0; k < NW; k++) begin
                w_reg[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < Nk; k++) begin
                            w_reg[k] <= key_in[32*k +: 32];
                        end
                        i_reg      <= 6'(Nk);
                        wrap_reg   <= '0;
                        rcon_reg   <= RCON_INIT;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                        state_reg  <= EXPAND;
                    end
                end
                EXPAND: begin
                    w_reg[i_reg] <= back_word ^ temp;
                    i_reg        <= i_reg + 6'd1;
                    wrap_reg     <= (wrap_reg == 3'(Nk - 1)) ? 3'd0 : wrap_reg + 3'd1;
                    if (wrap_reg == 3'd0) begin
                        rcon_reg <= xtime(rcon_reg);
                    end
                    if (i_reg == 6'(NW - 1)) begin
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    done       <= 1'b1;
                    keys_valid <= 1'b1;
                    busy       <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed FIPS-197 key-expansion vectors for all three key sizes plus
// ignore-while-busy, mid-run reset and back-to-back start scenarios.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic reset;
    logic start4, start6, start8;
    logic [0:127] key4;
    logic [0:191] key6;
    logic [0:255] key8;
    logic busy4, done4, valid4;
    logic busy6, done6, valid6;
    logic busy8, done8, valid8;
    logic [0:128*11-1] keys4;
    logic [0:128*13-1] keys6;
    logic [0:128*15-1] keys8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    aes_key_expand #(.Nk(4)) u_dut4 (
        .clks(clk), .reset(reset), .start(start4), .key_in(key4),
        .busy(busy4), .done(done4), .keys_valid(valid4), .keys(keys4)
    );
    aes_key_expand #(.Nk(6)) u_dut6 (
        .clks(clk), .reset(reset), .start(start6), .key_in(key6),
        .busy(busy6), .done(done6), .keys_valid(valid6), .keys(keys6)
    );
    aes_key_expand #(.Nk(8)) u_dut8 (
        .clks(clk), .reset(reset), .start(start8), .key_in(key8),
        .busy(busy8), .done(done8), .keys_valid(valid8), .keys(keys8)
    );

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_Z   = 128'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [31:0] word4(input int i);
        return keys4[32*i +: 32];
    endfunction
    function automatic logic [31:0] word6(input int i);
        return keys6[32*i +: 32];
    endfunction
    function automatic logic [31:0] word8(input int i);
        return keys8[32*i +: 32];
    endfunction

    function automatic logic get_done(input int which);
        case (which)
            4:       return done4;
            6:       return done6;
            default: return done8;
        endcase
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            4:       start4 = v;
            6:       start6 = v;
            default: start8 = v;
        endcase
    endtask

    // Drive start for one edge; returns #1 after the accepting edge.
    task automatic kick(input int which);
        set_start(which, 1'b1);
        @(posedge clk); #1;
        set_start(which, 1'b0);
    endtask

    // Watches a fixed window after the accepting edge; lat stays -1 if done never comes.
    task automatic wait_done(input int which, input int pulse_at, output int lat, output int pulses);
        lat = -1;
        pulses = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (n == pulse_at) begin
                start4 = 1'b1;
                key4   = KEY_Z;
            end else if (n == pulse_at + 1) begin
                start4 = 1'b0;
            end
            if (get_done(which)) begin
                pulses++;
                if (lat < 0) lat = n;
            end
        end
    endtask

    int lat, pulses;

    initial begin
        reset = 1'b1;
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        key4 = '0; key6 = '0; key8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy4), 64'd0);
        check("rst_done", 64'(done4), 64'd0);
        check("rst_valid", 64'(valid4), 64'd0);
        check("rst_keys_zero", 64'(|keys4), 64'd0);

        // Start coincident with reset is lost.
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_wins_busy", 64'(busy4), 64'd0);

        // Test 1: 128-bit key.
        key4 = KEY_A;
        kick(4);
        check("t1_busy", 64'(busy4), 64'd1);
        check("t1_valid_low", 64'(valid4), 64'd0);
        wait_done(4, -1, lat, pulses);
        check("t1_latency", 64'(lat), 64'd41);
        check("t1_pulses", 64'(pulses), 64'd1);
        check("t1_w0", 64'(word4(0)), 64'h2b7e1516);
        check("t1_w4", 64'(word4(4)), 64'ha0fafe17);
        check("t1_w5", 64'(word4(5)), 64'h88542cb1);
        check("t1_w8", 64'(word4(8)), 64'hf2c295f2);
        check("t1_w40", 64'(word4(40)), 64'hd014f9a8);
        check("t1_w43", 64'(word4(43)), 64'hb6630ca6);
        check("t1_valid", 64'(valid4), 64'd1);
        check("t1_busy_end", 64'(busy4), 64'd0);

        // Test 2: 192-bit key.
        key6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        kick(6);
        wait_done(6, -1, lat, pulses);
        check("t2_latency", 64'(lat), 64'd47);
        check("t2_w6", 64'(word6(6)), 64'hfe0c91f7);
        check("t2_w51", 64'(word6(51)), 64'h01002202);
        check("t2_valid", 64'(valid6), 64'd1);

        // Test 3: 256-bit key, including the SubWord-only step.
        key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        kick(8);
        wait_done(8, -1, lat, pulses);
        check("t3_latency", 64'(lat), 64'd53);
        check("t3_w8", 64'(word8(8)), 64'h9ba35411);
        check("t3_w12", 64'(word8(12)), 64'ha8b09c1a);
        check("t3_w59", 64'(word8(59)), 64'h706c631e);

        // Test 4: second start mid-expansion with another key is ignored.
        key4 = KEY_A;
        kick(4);
        wait_done(4, 10, lat, pulses);
        check("t4_latency", 64'(lat), 64'd41);
        check("t4_pulses", 64'(pulses), 64'd1);
        check("t4_w4", 64'(word4(4)), 64'ha0fafe17);
        check("t4_w43", 64'(word4(43)), 64'hb6630ca6);

        // Test 5: reset while word 20 is being written.
        key4 = KEY_A;
        kick(4);
        repeat (16) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_busy", 64'(busy4), 64'd0);
        check("t5_valid", 64'(valid4), 64'd0);
        check("t5_done", 64'(done4), 64'd0);
        check("t5_keys_zero", 64'(|keys4), 64'd0);
        reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (done4) pulses++;
        end
        check("t5_no_done", 64'(pulses), 64'd0);
        kick(4);
        wait_done(4, -1, lat, pulses);
        check("t5_latency", 64'(lat), 64'd41);
        check("t5_w4", 64'(word4(4)), 64'ha0fafe17);
        check("t5_w43", 64'(word4(43)), 64'hb6630ca6);

        // Test 6: start held high through FIN, key changed after first accept.
        key4 = KEY_A;
        start4 = 1'b1;
        @(posedge clk); #1;
        key4 = KEY_Z;
        lat = -1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = n;
                break;
            end
        end
        check("t6_first_latency", 64'(lat), 64'd41);
        check("t6_first_w43", 64'(word4(43)), 64'hb6630ca6);
        check("t6_first_valid", 64'(valid4), 64'd1);
        @(posedge clk); #1;
        start4 = 1'b0;
        check("t6_reaccept_busy", 64'(busy4), 64'd1);
        check("t6_reaccept_valid", 64'(valid4), 64'd0);
        check("t6_reaccept_done", 64'(done4), 64'd0);
        wait_done(4, -1, lat, pulses);
        check("t6_second_latency", 64'(lat), 64'd41);
        check("t6_second_w4", 64'(word4(4)), 64'h62636363);
        check("t6_second_w40", 64'(word4(40)), 64'hb4ef5bcb);
        check("t6_second_w43", 64'(word4(43)), 64'h6f8f188e);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
